day1_stream_ctrl: RTL

- Streaming controller for the day-1 calorie datapath.
- Replaces file-driven batch processing: a test harness or upstream line parser pushes entries over a valid/ready handshake.
- The block sequences per-group accumulation and top-3 insertion, then publishes the results.
- Outputs match the day-1 contract: out1 = largest group sum, out2 = sum of the three largest.

---
 rtl/day1_stream_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/day1_stream_ctrl.sv
// day1_stream_ctrl: streams calorie entries, accumulates groups, keeps top-3 and publishes out1/out2 (DAY1_STREAM_CTRL_SAT_EN selects saturating sums)
module day1_stream_ctrl #(
  parameter int WIDTH   = 64,
  parameter int ENTRY_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRY_W-1:0] in_data,
  input  logic               in_blank,
  input  logic               in_last,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out1,
  output logic [WIDTH-1:0]   out2,
  output logic [CNT_W-1:0]   group_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, INSERT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic [WIDTH-1:0] out1_q, out1_d, out2_q, out2_d, beat_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, accept;

  function automatic logic [WIDTH-1:0] add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef DAY1_STREAM_CTRL_SAT_EN
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  assign accept   = in_valid & in_ready;
  assign beat_sum = in_blank ? sum_q : add(sum_q, WIDTH'(in_data));

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    t3_d    = t3_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        sum_d   = '0;
        t1_d    = '0;
        t2_d    = '0;
        t3_d    = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
      ACCUM: if (accept) begin
        sum_d = beat_sum;
        if (in_last) begin
          pend_d  = 1'b1;
          state_d = (beat_sum != '0) ? INSERT : DONE;
        end else if (in_blank && sum_q != '0) state_d = INSERT;
      end
      INSERT: begin
        // strict compares place an equal sum below its twin, so ties are kept
        if (sum_q > t1_q) begin
          t3_d = t2_q;
          t2_d = t1_q;
          t1_d = sum_q;
        end else if (sum_q > t2_q) begin
          t3_d = t2_q;
          t2_d = sum_q;
        end else if (sum_q > t3_q) t3_d = sum_q;
        sum_d   = '0;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = pend_q ? DONE : ACCUM;
      end
      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
    endcase
    if (state_d == DONE && state_q != DONE) begin
      out1_d = t1_d;
      out2_d = add(add(t1_d, t2_d), t3_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      t3_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      t3_q    <= t3_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  assign in_ready    = state_q == ACCUM;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign group_count = cnt_q;
endmodule
